// File: rtl/sync_divider_pkg.sv
// Shared constants for the synchronous programmable divider.
// Direction encodings for the optional up/down build (SYNC_DIVIDER_UPDOWN_EN)
// and the default counter width used by sync_divider.
package sync_divider_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int SYNC_DIVIDER_DEFAULT_WIDTH = 27;

endpackage : sync_divider_pkg

// File: rtl/sync_divider.sv
// Fully synchronous programmable counter / clock divider with terminal-count pulse and 50% toggle.
// Latency: one edge; every output is a flop, no combinational input-to-output path.
// Backpressure: none; priority per edge is rst > load > en > hold.
// Optional down counting and the dir port exist only when SYNC_DIVIDER_UPDOWN_EN is defined.
module sync_divider
   import sync_divider_pkg::*;
#(
   parameter int               WIDTH     = SYNC_DIVIDER_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
`ifdef SYNC_DIVIDER_UPDOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             led
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_led;

   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;

   // Next count and terminal-count flag; max_val is taken fresh every edge so a
   // mid-count change simply feeds the compare/reload on the next step.
   always_comb begin
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      if (load) begin
         w_count_nxt = load_val;
      end else if (en) begin
`ifdef SYNC_DIVIDER_UPDOWN_EN
         if (dir == DIR_DOWN) begin
            // A count parked above max_val (via load) just walks down normally.
            if (r_count == '0) begin
               w_count_nxt = max_val;
               w_tc_nxt    = 1'b1;
            end else begin
               w_count_nxt = r_count - ONE;
            end
         end else
`endif
         begin
            // >= rather than == so a loaded value above max_val wraps immediately.
            if (r_count >= max_val) begin
               w_count_nxt = '0;
               w_tc_nxt    = 1'b1;
            end else begin
               w_count_nxt = r_count + ONE;
            end
         end
      end
   end

   // State registers: count, one-cycle tc pulse, and led toggling on each tc.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= RESET_VAL;
         r_tc    <= 1'b0;
         r_led   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
         r_led   <= r_led ^ w_tc_nxt;
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign led   = r_led;

endmodule : sync_divider

// File: tb/tb_sync_divider.sv
// Self-checking bench for sync_divider: directed scenarios then randomized traffic
// against a behavioural model. Down-mode scenarios run when SYNC_DIVIDER_UPDOWN_EN is defined.
`timescale 1ns/1ps
module tb_sync_divider;

   localparam int W = 8;
   localparam int MOD = 1 << W;
`ifdef SYNC_DIVIDER_UPDOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] max_val = '0;
   logic         dir = 1'b0;
   logic [W-1:0] count;
   logic         tc;
   logic         led;

   int n_checks = 0;
   int n_errors = 0;

   // reference state
   int  m_count = 0;
   bit  m_tc = 0;
   bit  m_led = 0;

   always #5 clk = ~clk;

   sync_divider #(.WIDTH(W), .RESET_VAL('0)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .max_val  (max_val),
`ifdef SYNC_DIVIDER_UPDOWN_EN
      .dir      (dir),
`endif
      .count    (count),
      .tc       (tc),
      .led      (led)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model per the divider rules, compare after the edge.
   task automatic step(input bit r, input bit e, input bit l, input int lv, input int mv, input bit d);
      rst = r; en = e; load = l; load_val = W'(lv); max_val = W'(mv); dir = d;
      @(posedge clk);
      if (r) begin
         m_count = 0; m_tc = 0; m_led = 0;
      end else if (l) begin
         m_count = lv % MOD; m_tc = 0;
      end else if (e) begin
         if (DOWN_EN && d) begin
            if (m_count == 0) begin m_count = mv % MOD; m_tc = 1; end
            else begin m_count = m_count - 1; m_tc = 0; end
         end else begin
            if (m_count >= mv) begin m_count = 0; m_tc = 1; end
            else begin m_count = (m_count + 1) % MOD; m_tc = 0; end
         end
         m_led = m_led ^ m_tc;
      end else begin
         m_tc = 0;
      end
      #1;
      chk("count", 32'(count), 32'(m_count));
      chk("tc",    32'(tc),    32'(m_tc));
      chk("led",   32'(led),   32'(m_led));
   endtask

   initial begin
      int tc_seen;
      int led_flips;
      bit prev_led;

      // Reset with en high for two cycles
      step(1, 1, 0, 0, 4, 0);
      chk("rst_count_const", 32'(count), 0);
      chk("rst_tc_const", 32'(tc), 0);
      chk("rst_led_const", 32'(led), 0);
      step(1, 1, 0, 0, 4, 0);

      // Up wrap with max_val=4: tc every 5 cycles, led period 10
      tc_seen = 0; led_flips = 0; prev_led = led;
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 0, 0, 4, 0);
         if (i == 4) chk("wrap_count_zero", 32'(count), 0);
         if (tc) tc_seen++;
         if (led != prev_led) led_flips++;
         prev_led = led;
      end
      chk("tc_per_20", 32'(tc_seen), 4);
      chk("led_flips_per_20", 32'(led_flips), 4);

      // Walk to count=2 then drop en for 3 cycles
      for (int i = 0; i < 10 && m_count != 2; i++) step(0, 1, 0, 0, 4, 0);
      chk("reach_two", 32'(count), 2);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4, 0);
      chk("hold_two", 32'(count), 2);

      // Load above max_val, then wrap to 0 with tc
      step(0, 1, 1, 9, 4, 0);
      chk("load_nine", 32'(count), 9);
      step(0, 1, 0, 0, 4, 0);
      chk("after_load_wrap_tc", 32'(tc), 1);
      // load and en together: load wins
      step(0, 1, 1, 3, 4, 0);
      chk("load_wins", 32'(count), 3);

      // Degenerate max_val=0
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
      chk("deg_tc", 32'(tc), 1);

`ifdef SYNC_DIVIDER_UPDOWN_EN
      // Down mode: max 3, load 0 -> 3,2,1,0,3...
      step(0, 1, 1, 0, 3, 1);
      tc_seen = 0;
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 0, 3, 1);
         if (i == 0) chk("down_first_wrap", 32'(count), 3);
         if (tc) tc_seen++;
      end
      chk("down_tc_per_16", 32'(tc_seen), 4);
      // count above max_val decrements normally
      step(0, 1, 1, 10, 3, 1);
      step(0, 1, 0, 0, 3, 1);
      chk("down_above_max", 32'(count), 9);
`endif

      // Reset mid-count: count=3, max 7
      step(0, 0, 1, 3, 7, 0);
      step(1, 1, 0, 0, 7, 0);
      chk("midrst_count", 32'(count), 0);
      step(0, 1, 0, 0, 7, 0);
      chk("resume_one", 32'(count), 1);
      step(0, 1, 0, 0, 7, 0);
      chk("resume_two", 32'(count), 2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int mv;
         mv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MOD - 1)) : int'($urandom_range(0, 12));
         step($urandom_range(0, 60) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 12) == 0,
              int'($urandom_range(0, MOD - 1)),
              mv,
              1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sync_divider
